// File: rtl/hamming_7_4_decoder_if.sv
// rtl/hamming_7_4_decoder_if.sv - stream and counter signals of the Hamming(7,4) decoder
interface hamming_7_4_decoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:1]       code_in;
  logic             out_valid;
  logic             out_ready;
  logic [1:4]       data_out;
  logic             err_corr;
  logic [2:0]       err_pos;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_cnt;

  // Upstream/downstream side: drives codewords, output backpressure and counter clear
  modport master (
    output in_valid, code_in, out_ready, cnt_clr,
    input  in_ready, out_valid, data_out, err_corr, err_pos, corr_cnt
  );

  // Decoder side
  modport slave (
    input  in_valid, code_in, out_ready, cnt_clr,
    output in_ready, out_valid, data_out, err_corr, err_pos, corr_cnt
  );
endinterface

// File: rtl/hamming_7_4_decoder.sv
// rtl/hamming_7_4_decoder.sv - two-stage Hamming(7,4) single-error-correcting decoder
module hamming_7_4_decoder #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_7_4_decoder_if.slave bus
);

  logic             en;
  logic             s1_valid;
  logic [7:1]       s1_code;
  logic [2:0]       s1_syn;
  logic             s2_valid;
  logic [1:4]       data_q;
  logic             err_corr_q;
  logic [2:0]       err_pos_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       syn;
  logic [2:0]       pos;
  logic [7:1]       fixed;

  // One advance enable for the whole pipe: it moves whenever the output slot is free or being taken
  assign en            = !s2_valid | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = s2_valid;
  assign bus.data_out  = data_q;
  assign bus.err_corr  = err_corr_q;
  assign bus.err_pos   = err_pos_q;
  assign bus.corr_cnt  = cnt_q;

  // Syndrome S = {s3,s2,s1} of the incoming codeword
  always_comb begin
    syn    = '0;
    syn[0] = bus.code_in[7] ^ bus.code_in[5] ^ bus.code_in[3] ^ bus.code_in[1];
    syn[1] = bus.code_in[6] ^ bus.code_in[5] ^ bus.code_in[2] ^ bus.code_in[1];
    syn[2] = bus.code_in[4] ^ bus.code_in[3] ^ bus.code_in[2] ^ bus.code_in[1];
  end

  // Error position is 8-S, which modulo 8 is simply -S and yields 0 for a clean word; flip that bit
  always_comb begin
    pos   = 3'd0 - s1_syn;
    fixed = s1_code;
    for (int i = 1; i <= 7; i++) begin
      if (pos == 3'(i)) begin
        fixed[i] = ~s1_code[i];
      end
    end
  end

  // Stage 1: capture codeword, syndrome and valid; bubbles are loaded too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_code  <= bus.code_in;
      s1_syn   <= syn;
    end
  end

  // Stage 2: corrected data and error status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      data_q     <= '0;
      err_corr_q <= 1'b0;
      err_pos_q  <= '0;
    end else if (en) begin
      s2_valid   <= s1_valid;
      data_q     <= {fixed[5], fixed[3], fixed[2], fixed[1]};
      err_corr_q <= |s1_syn;
      err_pos_q  <= pos;
    end
  end

  // Saturating count of corrected words handed downstream; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (s2_valid && bus.out_ready && err_corr_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_7_4_decoder.sv
// tb/tb_hamming_7_4_decoder.sv - scoreboard bench for hamming_7_4_decoder (CNT_W 16 and 2)
module tb_hamming_7_4_decoder;

  typedef struct {
    logic [3:0] data;
    logic       corr;
    logic [2:0] pos;
  } exp_t;

  typedef struct {
    logic [3:0] d;
    logic [2:0] e;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:1] code_in;
  logic       out_ready;
  logic       cnt_clr;

  int    checks   = 0;
  int    failures = 0;
  int    model_a  = 0;
  int    model_b  = 0;
  exp_t  sb[$];
  word_t txq[$];
  exp_t  exp_next;
  exp_t  mon_e;
  logic  mon_corr;

  always #5 clk = ~clk;

  hamming_7_4_decoder_if #(.CNT_W(16)) bus_a ();
  hamming_7_4_decoder_if #(.CNT_W(2))  bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.code_in   = code_in;
  assign bus_a.out_ready = out_ready;
  assign bus_a.cnt_clr   = cnt_clr;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.code_in   = code_in;
  assign bus_b.out_ready = out_ready;
  assign bus_b.cnt_clr   = cnt_clr;

  hamming_7_4_decoder #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  hamming_7_4_decoder #(.CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // d = {d1,d2,d3,d4}; e = code bit to flip (0 = none)
  function automatic logic [7:1] encode(input logic [3:0] d, input logic [2:0] e);
    logic [7:1] c;
    c[7] = d[3] ^ d[2] ^ d[0];
    c[6] = d[3] ^ d[1] ^ d[0];
    c[5] = d[3];
    c[4] = d[2] ^ d[1] ^ d[0];
    c[3] = d[2];
    c[2] = d[1];
    c[1] = d[0];
    if (e != 3'd0) c[e] = ~c[e];
    return c;
  endfunction

  // Scoreboard monitor: counter model, pop/compare on output handshake, push on input handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      model_a = 0;
      model_b = 0;
    end else begin
      chk("corr_cnt_a", bus_a.corr_cnt, model_a);
      chk("corr_cnt_b", bus_b.corr_cnt, model_b);
      mon_corr = 1'b0;
      if (bus_a.out_valid && out_ready) begin
        chk("output_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          mon_corr = mon_e.corr;
          chk("data_out_a", bus_a.data_out, mon_e.data);
          chk("err_corr_a", bus_a.err_corr, mon_e.corr);
          chk("err_pos_a",  bus_a.err_pos,  mon_e.pos);
          chk("out_valid_b", bus_b.out_valid, 1);
          chk("data_out_b", bus_b.data_out, mon_e.data);
          chk("err_corr_b", bus_b.err_corr, mon_e.corr);
          chk("err_pos_b",  bus_b.err_pos,  mon_e.pos);
        end
      end
      if (cnt_clr) begin
        model_a = 0;
        model_b = 0;
      end else if (mon_corr) begin
        if (model_a < 65535) model_a++;
        if (model_b < 3)     model_b++;
      end
      if (in_valid && bus_a.in_ready) sb.push_back(exp_next);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int stall_start, input int stall_len);
    int c = 0;
    bit acc;
    while (txq.size() > 0 && c < 400) begin
      out_ready = !(c >= stall_start && c < stall_start + stall_len);
      in_valid  = 1'b1;
      code_in   = encode(txq[0].d, txq[0].e);
      exp_next.data = txq[0].d;
      exp_next.corr = (txq[0].e != 3'd0);
      exp_next.pos  = txq[0].e;
      #1;
      acc = bus_a.in_ready;
      if (!out_ready && c >= 2) begin
        chk("stall_in_ready",  bus_a.in_ready,  0);
        chk("stall_out_valid", bus_a.out_valid, 1);
        if (sb.size() > 0) begin
          chk("stall_data", bus_a.data_out, sb[0].data);
          chk("stall_corr", bus_a.err_corr, sb[0].corr);
          chk("stall_pos",  bus_a.err_pos,  sb[0].pos);
        end
      end
      @(posedge clk);
      #1;
      if (acc) void'(txq.pop_front());
      c++;
    end
    in_valid = 1'b0;
    chk("stream_timeout", txq.size(), 0);
  endtask

  task automatic drain();
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() > 0 || bus_a.out_valid) && c < 50) begin
      cyc();
      c++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic single(input logic [7:1] code, input logic [3:0] d, input logic [2:0] p);
    out_ready     = 1'b1;
    in_valid      = 1'b1;
    code_in       = code;
    exp_next.data = d;
    exp_next.corr = (p != 3'd0);
    exp_next.pos  = p;
    cyc();
    in_valid = 1'b0;
    chk("latency_not_early", bus_a.out_valid, 0);
    cyc();
    chk("latency_out_valid", bus_a.out_valid, 1);
    chk("latency_data",      bus_a.data_out,  d);
    chk("latency_err_corr",  bus_a.err_corr,  (p != 3'd0));
    chk("latency_err_pos",   bus_a.err_pos,   p);
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    code_in   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    exp_next  = '{data: 4'd0, corr: 1'b0, pos: 3'd0};
    #1;
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_data_out",  bus_a.data_out,  0);
    chk("rst_err_corr",  bus_a.err_corr,  0);
    chk("rst_err_pos",   bus_a.err_pos,   0);
    chk("rst_corr_cnt",  bus_a.corr_cnt,  0);
    chk("rst_in_ready",  bus_a.in_ready,  1);
    @(posedge clk);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Directed words: clean, data-bit 5 error, parity-bit 7 error
    single(7'b0110011, 4'b1011, 3'd0);
    chk("clean_cnt", bus_a.corr_cnt, 0);
    single(7'b0100011, 4'b1011, 3'd5);
    chk("bit5_cnt", bus_a.corr_cnt, 1);
    single(7'b1110011, 4'b1011, 3'd7);
    chk("bit7_cnt", bus_a.corr_cnt, 2);

    // Full sweep: 16 data values x (no error, bits 1..7), back to back
    for (int d = 0; d < 16; d++)
      for (int e = 0; e < 8; e++)
        txq.push_back('{d: 4'(d), e: 3'(e)});
    stream(0, 0);
    drain();
    chk("sweep_cnt_a", bus_a.corr_cnt, 114);
    chk("sweep_cnt_b", bus_b.corr_cnt, 3);

    // Backpressure: out_ready low 3 cycles in the middle of a stream
    for (int i = 0; i < 8; i++)
      txq.push_back('{d: 4'(i * 3 + 1), e: 3'(i % 8)});
    stream(4, 3);
    drain();

    // Saturation and clear on the narrow counter
    rst_n = 1'b0;
    sb.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++)
      txq.push_back('{d: 4'(i + 6), e: 3'(i + 1)});
    stream(0, 0);
    drain();
    chk("sat_cnt_b", bus_b.corr_cnt, 3);
    chk("sat_cnt_a", bus_a.corr_cnt, 5);
    txq.push_back('{d: 4'b0101, e: 3'd2});
    stream(0, 0);
    for (int k = 0; k < 10 && !bus_a.out_valid; k++) cyc();
    chk("clr_word_ready", bus_a.out_valid, 1);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("clr_cnt_a", bus_a.corr_cnt, 0);
    chk("clr_cnt_b", bus_b.corr_cnt, 0);
    drain();

    // Mid-stream reset with both stages full
    txq.push_back('{d: 4'b1100, e: 3'd3});
    stream(0, 0);
    drain();
    chk("pre_rst_cnt", bus_a.corr_cnt, 1);
    txq.push_back('{d: 4'b0011, e: 3'd6});
    txq.push_back('{d: 4'b1110, e: 3'd1});
    stream(0, 100);
    chk("full_in_ready",  bus_a.in_ready,  0);
    chk("full_out_valid", bus_a.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus_a.out_valid, 0);
    chk("midrst_cnt_a",     bus_a.corr_cnt,  0);
    chk("midrst_cnt_b",     bus_b.corr_cnt,  0);
    chk("midrst_in_ready",  bus_a.in_ready,  1);
    sb.delete();
    out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle0", bus_a.out_valid, 0);
    cyc();
    chk("post_rst_idle1", bus_a.out_valid, 0);
    txq.push_back('{d: 4'b1001, e: 3'd0});
    stream(0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_7_4_decoder.md
HAMMING_7_4_DECODER -- requirements
Module: hamming_7_4_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the corrected-word counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  code_in holds a valid codeword.
REQ-005 SHALL have port in_ready  output  1  decoder accepts code_in this cycle.
REQ-006 SHALL have port code_in  input  [7:1]  codeword {p1,p2,d1,p3,d2,d3,d4}, bit 7 = p1, bit 1 = d4.
REQ-007 SHALL have port out_valid  output  1  data_out and status are valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts output this cycle.
REQ-009 SHALL have port data_out  output  [1:4]  corrected data {d1,d2,d3,d4}.
REQ-010 SHALL have port err_corr  output  1  a single-bit error was corrected in this word.
REQ-011 SHALL have port err_pos  output  [2:0]  corrected code bit position 1..7; 0 if no error.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of corr_cnt.
REQ-013 SHALL have port corr_cnt  output  [CNT_W-1:0]  saturating count of corrected words delivered.

Function
REQ-014 SHALL define the encoder parity as p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
REQ-015 SHALL compute syndrome s1=c7^c5^c3^c1, s2=c6^c5^c2^c1, s3=c4^c3^c2^c1, with S={s3,s2,s1}.
REQ-016 SHALL treat S=0 as error-free, and S!=0 as a single-bit error at code position 8-S (S=1 -> bit 7 ... S=7 -> bit 1).
REQ-017 SHALL invert the erroneous bit before extracting data_out, so a parity-bit error (positions 7, 6, 4) leaves data unchanged but still sets err_corr.
REQ-018 SHALL be single-error-correcting only; double-bit errors are miscorrected without any flag.
REQ-019 SHALL be a 2-stage pipeline: stage 1 registers the codeword and S; stage 2 registers data_out, err_corr and err_pos.
REQ-020 SHALL have a latency of 2 cycles from an input handshake to out_valid when out_ready stays high.
REQ-021 SHALL make an input handshake in_valid&in_ready and an output handshake out_valid&out_ready.
REQ-022 SHALL use a global advance enable en = !out_valid | out_ready, with in_ready = en.
REQ-023 SHALL hold both stages when en=0: data, status and valid bits stay stable and no word is lost or duplicated.
REQ-024 SHALL NOT collapse bubbles; a stage loads in_valid (stage 1) or the stage-1 valid (stage 2) whenever en=1.
REQ-025 SHALL deliver back-to-back words at one word per cycle when in_valid and out_ready are continuously high.
REQ-026 SHALL increment corr_cnt by 1 on each output handshake with err_corr=1.
REQ-027 SHALL saturate corr_cnt at 2^CNT_W-1, with no wrap-around.
REQ-028 SHALL give cnt_clr priority over an increment in the same cycle, so corr_cnt becomes 0.
REQ-029 SHALL have outputs that depend only on registers; there is no combinational path from code_in to any output.

Reset
REQ-030 SHALL clear on rst_n low, immediately and independent of clk: both stage valid bits (out_valid=0), data_out=0, err_corr=0, err_pos=0, corr_cnt=0.
REQ-031 SHALL drive in_ready=1 while in reset, since out_valid=0.
REQ-032 SHALL discard any in-flight words when rst_n is asserted mid-stream; the first output after release comes from a word accepted after release.
REQ-033 SHALL begin normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-034 SHALL check the clean word: code_in=7'b0110011, out_ready=1 -> 2 cycles later data_out=4'b1011, err_corr=0, err_pos=0, corr_cnt unchanged.
REQ-035 SHALL check the data-bit error: code_in=7'b0100011 (bit 5 flipped) -> data_out=4'b1011, err_corr=1, err_pos=5, corr_cnt +1.
REQ-036 SHALL check the parity-bit error: code_in=7'b1110011 (bit 7 flipped) -> data_out=4'b1011, err_corr=1, err_pos=7; then sweep all 16 data values x 8 error cases (none, bits 1..7) for exact correction.
REQ-037 SHALL check backpressure: a continuous stream with out_ready held low 3 cycles -> in_ready=0 during the stall, outputs stable, order preserved, none lost.
REQ-038 SHALL check saturation and clear with CNT_W=2: 5 corrected words -> corr_cnt=3; cnt_clr asserted together with a corrected handshake -> corr_cnt=0.
REQ-039 SHALL check mid-stream reset: rst_n pulsed low with both stages full -> out_valid=0 and corr_cnt=0 at once, and no stale word after release.
